// File: rtl/div_unit_pkg.sv
// Shared constants and helpers for the EX-stage radix-2 restoring divider.
package div_unit_pkg;

    localparam logic        Stop       = 1'b1;
    localparam logic        NoStop     = 1'b0;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    localparam logic [1:0]  DivIdle    = 2'b00;
    localparam logic [1:0]  DivBusy    = 2'b01;
    localparam logic [1:0]  DivDone    = 2'b10;

    localparam int          DivCycles  = 32;
    localparam logic [4:0]  DivLastCnt = 5'(DivCycles - 1);

    typedef enum logic [1:0] {
        DIV_IDLE = DivIdle,
        DIV_BUSY = DivBusy,
        DIV_DONE = DivDone
    } div_state_e;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] op_mag(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            op_mag = ~v + 32'd1;
        end else begin
            op_mag = v;
        end
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] dvd_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic [31:0] dvd_o,
    output logic        q_bit_o
);

    logic [32:0] rem_sh_s;
    logic [32:0] diff_s;

    // The shifted remainder may need bit 32, so the trial subtract is 33 bits wide.
    always_comb begin
        rem_sh_s = {rem_i, dvd_i[31]};
        diff_s   = rem_sh_s - {1'b0, dvs_i};
        q_bit_o  = ~diff_s[32];
        dvd_o    = {dvd_i[30:0], 1'b0};
        if (q_bit_o) begin
            rem_o = diff_s[31:0];
        end else begin
            rem_o = rem_sh_s[31:0];
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider for EX; stalls the pipe while busy, drops work on flush.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        annul_i,
    input  logic        accept_i,
    output logic        stallreq_o,
    output logic        result_valid_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    div_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] quot_q;
    logic        q_neg_q;
    logic        r_neg_q;

    logic [31:0] rem_d;
    logic [31:0] dvd_d;
    logic        q_bit_d;
    logic        valid_s;

    div_step u_step (
        .rem_i   (rem_q),
        .dvd_i   (dvd_q),
        .dvs_i   (dvs_q),
        .rem_o   (rem_d),
        .dvd_o   (dvd_d),
        .q_bit_o (q_bit_d)
    );

    // Control FSM and iteration datapath; annul overrides every other request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= ZeroWord;
            dvd_q   <= ZeroWord;
            dvs_q   <= ZeroWord;
            quot_q  <= ZeroWord;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (annul_i) begin
            state_q <= DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        cnt_q <= 5'd0;
                        dvd_q <= op_mag(dividend_i, signed_i);
                        dvs_q <= op_mag(divisor_i, signed_i);
                        // Divide-by-zero bypasses iteration and reports the raw dividend.
                        if (divisor_i == ZeroWord) begin
                            state_q <= DIV_DONE;
                            quot_q  <= 32'hFFFF_FFFF;
                            rem_q   <= dividend_i;
                            q_neg_q <= 1'b0;
                            r_neg_q <= 1'b0;
                        end else begin
                            state_q <= DIV_BUSY;
                            quot_q  <= ZeroWord;
                            rem_q   <= ZeroWord;
                            q_neg_q <= signed_i & (dividend_i[31] ^ divisor_i[31]);
                            r_neg_q <= signed_i & dividend_i[31];
                        end
                    end else begin
                        state_q <= DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    // A withdrawn instruction without a flush is wrong-path: abandon it.
                    if (!start_i) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q  <= rem_d;
                        dvd_q  <= dvd_d;
                        quot_q <= {quot_q[30:0], q_bit_d};
                        if (cnt_q == DivLastCnt) begin
                            state_q <= DIV_DONE;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                DIV_DONE: begin
                    if (accept_i) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        state_q <= DIV_DONE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign stallreq_o = (start_i && !annul_i && (state_q != DIV_DONE)) ? Stop : NoStop;

    // Sign fix-up on the held magnitudes; outputs read zero whenever no result is offered.
    always_comb begin
        valid_s        = (state_q == DIV_DONE) && !annul_i;
        result_valid_o = valid_s;
        quotient_o     = ZeroWord;
        remainder_o    = ZeroWord;
        if (valid_s) begin
            quotient_o  = q_neg_q ? (~quot_q + 32'd1) : quot_q;
            remainder_o = r_neg_q ? (~rem_q + 32'd1) : rem_q;
        end else begin
            quotient_o  = ZeroWord;
            remainder_o = ZeroWord;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] dividend_i = 32'd0;
    logic [31:0] divisor_i = 32'd0;
    logic        annul_i = 1'b0;
    logic        accept_i = 1'b0;
    logic        stallreq_o;
    logic        result_valid_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit          chk_en = 1'b0;
    bit          op_active = 1'b0;
    int          issue_cyc = 0;
    int          exp_lat = 0;
    logic [31:0] exp_q = 32'd0;
    logic [31:0] exp_r = 32'd0;

    div_unit dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .signed_i       (signed_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .annul_i        (annul_i),
        .accept_i       (accept_i),
        .stallreq_o     (stallreq_o),
        .result_valid_o (result_valid_o),
        .quotient_o     (quotient_o),
        .remainder_o    (remainder_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero; x/0 gives all-ones and x.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q = sq[31:0];
            r = sr[31:0];
        end
    endtask

    // Per-cycle compare: expected handshake derived from elapsed cycles since issue.
    always @(negedge clk) begin
        int  elapsed;
        bit  ev;
        bit  es;
        if (chk_en) begin
            elapsed = cyc - issue_cyc;
            ev = op_active && !annul_i && (elapsed >= exp_lat);
            es = start_i && !annul_i && !ev;
            chk("stallreq", {31'd0, stallreq_o}, {31'd0, es});
            chk("result_valid", {31'd0, result_valid_o}, {31'd0, ev});
            if (ev) begin
                chk("quotient", quotient_o, exp_q);
                chk("remainder", remainder_o, exp_r);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, result_valid_o}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stallreq_o}, 32'd0);
        chk({tag, "_quot"}, quotient_o, 32'd0);
        chk({tag, "_rem"}, remainder_o, 32'd0);
    endtask

    // kind: 0 none, 1 annul, 2 drop start, 3 reset; applied abort_at cycles after issue.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                          input int hold, input int kind, input int abort_at);
        logic [31:0] mq;
        logic [31:0] mr;
        model(a, b, sgn, mq, mr);
        start_i    = 1'b1;
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        accept_i   = 1'b0;
        exp_q      = mq;
        exp_r      = mr;
        exp_lat    = (b == 32'd0) ? 1 : 33;
        issue_cyc  = cyc;
        op_active  = 1'b1;
        if (kind != 0) begin
            repeat (abort_at) next();
            if (kind == 1) begin
                annul_i = 1'b1;
                next();
                annul_i   = 1'b0;
                start_i   = 1'b0;
                op_active = 1'b0;
            end else if (kind == 2) begin
                start_i   = 1'b0;
                op_active = 1'b0;
                next();
            end else begin
                rst       = 1'b1;
                start_i   = 1'b0;
                op_active = 1'b0;
                next();
                chk_zero_outputs("reset_mid_busy");
                rst = 1'b0;
            end
        end else begin
            repeat (exp_lat + hold) next();
            accept_i = 1'b1;
            next();
            accept_i  = 1'b0;
            start_i   = 1'b0;
            op_active = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] pq;
        logic [31:0] pr;
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        int          hold;
        int          kind;
        int          at;
        int          sel;
        int          lat;

        model(32'd100, 32'd7, 1'b0, pq, pr);
        chk("model_100_7_q", pq, 32'd14);
        chk("model_100_7_r", pr, 32'd2);
        model(32'hFFFF_FFF9, 32'd2, 1'b1, pq, pr);
        chk("model_m7_2_q", pq, 32'hFFFF_FFFD);
        chk("model_m7_2_r", pr, 32'hFFFF_FFFF);
        model(32'd5, 32'd0, 1'b0, pq, pr);
        chk("model_5_0_q", pq, 32'hFFFF_FFFF);
        chk("model_5_0_r", pr, 32'd5);
        model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, pq, pr);
        chk("model_ovf_q", pq, 32'h8000_0000);
        chk("model_ovf_r", pr, 32'd0);

        repeat (2) next();
        chk_zero_outputs("after_reset");
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 0, 0, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0, 0);
        run_op(32'd5, 32'd0, 1'b0, 0, 0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
        run_op(32'd77, 32'd5, 1'b0, 0, 1, 10);
        run_op(32'd9, 32'd3, 1'b0, 0, 0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 3, 0, 0);
        run_op(32'd12345, 32'd17, 1'b0, 0, 3, 15);
        run_op(32'd50, 32'hFFFF_FFFA, 1'b1, 0, 0, 0);
        run_op(32'd20, 32'd3, 1'b0, 2, 1, 34);
        run_op(32'hFFFF_FC18, 32'd9, 1'b1, 0, 2, 5);
        run_op(32'hFFFF_FFF0, 32'd0, 1'b1, 1, 0, 0);
        next();

        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            sgn  = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            lat  = (b == 32'd0) ? 1 : 33;
            kind = 0;
            at   = 0;
            sel  = $urandom_range(0, 9);
            if (sel == 0) begin
                kind = 1;
                at   = $urandom_range(0, lat);
            end else if (sel == 1 && b != 32'd0) begin
                kind = 2;
                at   = $urandom_range(1, 32);
            end else begin
                kind = 0;
            end
            run_op(a, b, sgn, hold, kind, at);
            if ($urandom_range(0, 1) == 1) next();
        end

        repeat (3) next();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
